// File: rtl/rfBlackWidowPkg.sv
// Shared types for the RF Black Widow issue scheduler: register-number type
// and the two-state scheduler encoding.
package rfBlackWidowPkg;

    localparam int REGW_DEF = 6;
    localparam int CNTW_DEF = 16;

    typedef logic [REGW_DEF-1:0] reg_num_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rfbw_dep_chk.sv
// Pairwise hazard check: can the younger slot join a group that already
// contains the older slot?
module rfbw_dep_chk #(
    parameter int REGW = 6
) (
    input  logic [REGW-1:0] old_rt,
    input  logic            old_rfwr,
    input  logic            old_br,
    input  logic [REGW-1:0] yng_ra,
    input  logic [REGW-1:0] yng_rb,
    input  logic [REGW-1:0] yng_rc,
    input  logic [REGW-1:0] yng_rt,
    input  logic            yng_rfwr,
    output logic            hazard
);

    logic old_writes;
    logic raw;
    logic waw;

    // Writes to r0 are discarded, so they never create a dependency.
    always_comb begin
        old_writes = old_rfwr && (old_rt != '0);
        raw        = old_writes && ((yng_ra == old_rt) || (yng_rb == old_rt) || (yng_rc == old_rt));
        waw        = old_writes && yng_rfwr && (yng_rt == old_rt);
        hazard     = raw || waw || old_br;
    end

endmodule

// File: rtl/rfbw_issue_sched.sv
// Holds one 3-slot bundle and issues it as one or more hazard-free groups,
// oldest slot first, counting bundles that needed splitting.
module rfbw_issue_sched
    import rfBlackWidowPkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bnd_v_i,
    output logic                 bnd_rdy_o,
    input  logic [2:0]           slot_v_i,
    input  logic [2:0][REGW-1:0] ra_i,
    input  logic [2:0][REGW-1:0] rb_i,
    input  logic [2:0][REGW-1:0] rc_i,
    input  logic [2:0][REGW-1:0] rt_i,
    input  logic [2:0]           rfwr_i,
    input  logic [2:0]           br_i,
    output logic [2:0]           iss_v_o,
    input  logic                 iss_rdy_i,
    output logic                 iss_last_o,
    input  logic                 flush_i,
    output logic [CNTW-1:0]      split_cnt_o
);

    sched_state_t         state_q, state_d;
    logic [2:0]           pend_q, pend_d;
    logic                 first_q, first_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [2:0][REGW-1:0] ra_q, rb_q, rc_q, rt_q;
    logic [2:0]           rfwr_q, br_q;

    logic       h01, h02, h12;
    logic [2:0] grp;
    logic       accept;
    logic       capture;
    logic       unused_fields;

    // Slot 0 is never the younger side and slot 2 never the older side.
    assign unused_fields = ^{ra_q[0], rb_q[0], rc_q[0], br_q[2]};

    rfbw_dep_chk #(.REGW(REGW)) u_dep_01 (
        .old_rt(rt_q[0]), .old_rfwr(rfwr_q[0]), .old_br(br_q[0]),
        .yng_ra(ra_q[1]), .yng_rb(rb_q[1]), .yng_rc(rc_q[1]),
        .yng_rt(rt_q[1]), .yng_rfwr(rfwr_q[1]), .hazard(h01)
    );

    rfbw_dep_chk #(.REGW(REGW)) u_dep_02 (
        .old_rt(rt_q[0]), .old_rfwr(rfwr_q[0]), .old_br(br_q[0]),
        .yng_ra(ra_q[2]), .yng_rb(rb_q[2]), .yng_rc(rc_q[2]),
        .yng_rt(rt_q[2]), .yng_rfwr(rfwr_q[2]), .hazard(h02)
    );

    rfbw_dep_chk #(.REGW(REGW)) u_dep_12 (
        .old_rt(rt_q[1]), .old_rfwr(rfwr_q[1]), .old_br(br_q[1]),
        .yng_ra(ra_q[2]), .yng_rb(rb_q[2]), .yng_rc(rc_q[2]),
        .yng_rt(rt_q[2]), .yng_rfwr(rfwr_q[2]), .hazard(h12)
    );

    // Grow the group from the lowest pending slot and stop at the first
    // pending slot that conflicts with anything already in it.
    always_comb begin
        grp = 3'b000;
        if (pend_q[0]) begin
            grp[0] = 1'b1;
            if (pend_q[1]) begin
                grp[1] = !h01;
                grp[2] = pend_q[2] && !h01 && !h02 && !h12;
            end else begin
                grp[2] = pend_q[2] && !h02;
            end
        end else if (pend_q[1]) begin
            grp[1] = 1'b1;
            grp[2] = pend_q[2] && !h12;
        end else begin
            grp[2] = pend_q[2];
        end
    end

    always_comb begin
        iss_v_o     = (state_q == ISSUE) ? grp : 3'b000;
        iss_last_o  = (state_q == ISSUE) && (grp != 3'b000) && (grp == pend_q);
        accept      = (state_q == ISSUE) && (grp != 3'b000) && iss_rdy_i;
        bnd_rdy_o   = !flush_i && ((state_q == IDLE) || (accept && iss_last_o));
        capture     = bnd_v_i && bnd_rdy_o;
        split_cnt_o = cnt_q;

        pend_d  = pend_q;
        first_d = first_q;
        cnt_d   = cnt_q;

        if (accept && first_q && !iss_last_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
        if (accept) begin
            pend_d  = pend_q & ~grp;
            first_d = 1'b0;
        end
        if (flush_i) begin
            pend_d = 3'b000;
        end
        if (capture) begin
            pend_d  = slot_v_i;
            first_d = 1'b1;
        end
        state_d = (pend_d != 3'b000) ? ISSUE : IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= 3'b000;
            first_q <= 1'b0;
            cnt_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            rt_q    <= '0;
            rfwr_q  <= 3'b000;
            br_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                ra_q   <= ra_i;
                rb_q   <= rb_i;
                rc_q   <= rc_i;
                rt_q   <= rt_i;
                rfwr_q <= rfwr_i;
                br_q   <= br_i;
            end
        end
    end

endmodule

// File: tb/tb_rfbw_issue_sched.sv
// Table-driven bench for rfbw_issue_sched with a queue scoreboard of expected
// issue groups, plus hand-written stall, flush, back-to-back and reset cases.
module tb_rfbw_issue_sched;
    import rfBlackWidowPkg::*;

    typedef struct {
        logic [2:0]       slot_v;
        reg_num_t [2:0]   ra;
        reg_num_t [2:0]   rb;
        reg_num_t [2:0]   rc;
        reg_num_t [2:0]   rt;
        logic [2:0]       rfwr;
        logic [2:0]       br;
        int               ngrp;
        logic [2:0][2:0]  grp;
    } vec_t;

    typedef struct packed {
        logic [2:0] grp;
        logic       last;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            bnd_v_i;
    logic            bnd_rdy_o;
    logic [2:0]      slot_v_i;
    logic [2:0][5:0] ra_i, rb_i, rc_i, rt_i;
    logic [2:0]      rfwr_i, br_i;
    logic [2:0]      iss_v_o;
    logic            iss_rdy_i;
    logic            iss_last_o;
    logic            flush_i;
    logic [15:0]     split_cnt_o;

    logic            sat_bnd_rdy;
    logic [2:0]      sat_iss_v;
    logic            sat_last;
    logic [1:0]      sat_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] exp_split = 16'd0;
    logic [1:0]  exp_sat = 2'd0;
    vec_t        vecs[10];

    always #5 clk_i = ~clk_i;

    rfbw_issue_sched dut (
        .clk_i(clk_i), .rst_i(rst_i), .bnd_v_i(bnd_v_i), .bnd_rdy_o(bnd_rdy_o),
        .slot_v_i(slot_v_i), .ra_i(ra_i), .rb_i(rb_i), .rc_i(rc_i), .rt_i(rt_i),
        .rfwr_i(rfwr_i), .br_i(br_i), .iss_v_o(iss_v_o), .iss_rdy_i(iss_rdy_i),
        .iss_last_o(iss_last_o), .flush_i(flush_i), .split_cnt_o(split_cnt_o)
    );

    // A 2-bit counter copy reaches all-ones within the run, exercising saturation.
    rfbw_issue_sched #(.REGW(6), .CNTW(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .bnd_v_i(bnd_v_i), .bnd_rdy_o(sat_bnd_rdy),
        .slot_v_i(slot_v_i), .ra_i(ra_i), .rb_i(rb_i), .rc_i(rc_i), .rt_i(rt_i),
        .rfwr_i(rfwr_i), .br_i(br_i), .iss_v_o(sat_iss_v), .iss_rdy_i(iss_rdy_i),
        .iss_last_o(sat_last), .flush_i(flush_i), .split_cnt_o(sat_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_slot(input int v, input int s, input int rt, input int ra, input int rb,
                            input int rc, input logic wr, input logic br);
        vecs[v].rt[s]   = reg_num_t'(rt);
        vecs[v].ra[s]   = reg_num_t'(ra);
        vecs[v].rb[s]   = reg_num_t'(rb);
        vecs[v].rc[s]   = reg_num_t'(rc);
        vecs[v].rfwr[s] = wr;
        vecs[v].br[s]   = br;
    endtask

    task automatic set_exp(input int v, input logic [2:0] sv, input int n,
                           input logic [2:0] g0, input logic [2:0] g1, input logic [2:0] g2);
        vecs[v].slot_v = sv;
        vecs[v].ngrp   = n;
        vecs[v].grp[0] = g0;
        vecs[v].grp[1] = g1;
        vecs[v].grp[2] = g2;
    endtask

    task automatic scoreboard();
        exp_t e;
        if (iss_v_o != 3'b000 && iss_rdy_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_issue", 32'(iss_v_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_grp", 32'(iss_v_o), 32'(e.grp));
                checkOutput("sb_last", 32'(iss_last_o), 32'(e.last));
                checkOutput("sb_sat_grp", 32'(sat_iss_v), 32'(e.grp));
                checkOutput("sb_sat_last", 32'(sat_last), 32'(e.last));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        scoreboard();
        @(posedge clk_i);
        #1;
    endtask

    task automatic driveBundle(input vec_t v);
        slot_v_i = v.slot_v;
        ra_i     = v.ra;
        rb_i     = v.rb;
        rc_i     = v.rc;
        rt_i     = v.rt;
        rfwr_i   = v.rfwr;
        br_i     = v.br;
    endtask

    task automatic pushExpect(input vec_t v);
        for (int k = 0; k < v.ngrp; k++) begin
            exp_q.push_back('{grp: v.grp[k], last: (k == v.ngrp - 1)});
        end
        if (v.ngrp > 1) begin
            if (exp_split != 16'hFFFF) exp_split = exp_split + 16'd1;
            if (exp_sat != 2'b11) exp_sat = exp_sat + 2'd1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pushExpect(v);
        driveBundle(v);
        bnd_v_i = 1'b1;
        tick();
        bnd_v_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_split"}, 32'(split_cnt_o), 32'(exp_split));
        checkOutput({tag, "_sat"}, 32'(sat_cnt), 32'(exp_sat));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i = 1'b1; bnd_v_i = 1'b0; slot_v_i = 3'b000;
        ra_i = '0; rb_i = '0; rc_i = '0; rt_i = '0;
        rfwr_i = 3'b000; br_i = 3'b000; iss_rdy_i = 1'b1; flush_i = 1'b0;

        // slot:    v  s  rt  ra  rb  rc  wr    br
        set_slot(0, 0, 1,  2,  0,  0, 1'b1, 1'b0); set_slot(0, 1, 3,  4, 0, 0, 1'b1, 1'b0);
        set_slot(0, 2, 5,  6,  0,  0, 1'b1, 1'b0); set_exp(0, 3'b111, 1, 3'b111, 3'b000, 3'b000);
        set_slot(1, 0, 7,  1,  0,  0, 1'b1, 1'b0); set_slot(1, 1, 8,  1, 7, 0, 1'b1, 1'b0);
        set_slot(1, 2, 9,  2,  0,  0, 1'b1, 1'b0); set_exp(1, 3'b111, 2, 3'b001, 3'b110, 3'b000);
        set_slot(2, 0, 0,  1,  0,  0, 1'b0, 1'b1); set_slot(2, 1, 10, 11, 0, 0, 1'b1, 1'b0);
        set_slot(2, 2, 12, 13, 0,  0, 1'b1, 1'b0); set_exp(2, 3'b111, 2, 3'b001, 3'b110, 3'b000);
        set_slot(3, 0, 0,  2,  0,  0, 1'b1, 1'b0); set_slot(3, 1, 1,  0, 0, 0, 1'b1, 1'b0);
        set_slot(3, 2, 2,  3,  0,  0, 1'b1, 1'b0); set_exp(3, 3'b111, 1, 3'b111, 3'b000, 3'b000);
        set_slot(4, 0, 5,  1,  0,  0, 1'b1, 1'b0); set_slot(4, 1, 5,  2, 0, 0, 1'b1, 1'b0);
        set_slot(4, 2, 6,  3,  0,  0, 1'b1, 1'b0); set_exp(4, 3'b111, 2, 3'b001, 3'b110, 3'b000);
        set_slot(5, 0, 1,  2,  0,  0, 1'b1, 1'b0); set_slot(5, 1, 3,  4, 0, 0, 1'b1, 1'b0);
        set_slot(5, 2, 5,  0,  0,  3, 1'b1, 1'b0); set_exp(5, 3'b111, 2, 3'b011, 3'b100, 3'b000);
        set_slot(6, 0, 1,  2,  0,  0, 1'b1, 1'b0); set_slot(6, 1, 7,  0, 0, 0, 1'b1, 1'b0);
        set_slot(6, 2, 3,  1,  0,  0, 1'b1, 1'b0); set_exp(6, 3'b101, 2, 3'b001, 3'b100, 3'b000);
        set_slot(7, 0, 0,  0,  0,  0, 1'b0, 1'b0); set_slot(7, 1, 1,  2, 0, 0, 1'b1, 1'b0);
        set_slot(7, 2, 0,  0,  0,  0, 1'b0, 1'b0); set_exp(7, 3'b010, 1, 3'b010, 3'b000, 3'b000);
        set_slot(8, 0, 1,  2,  0,  0, 1'b1, 1'b0); set_slot(8, 1, 2,  1, 0, 0, 1'b1, 1'b0);
        set_slot(8, 2, 3,  2,  0,  0, 1'b1, 1'b0); set_exp(8, 3'b111, 3, 3'b001, 3'b010, 3'b100);
        set_slot(9, 0, 1,  2,  0,  0, 1'b1, 1'b0); set_slot(9, 1, 0,  3, 0, 0, 1'b0, 1'b1);
        set_slot(9, 2, 4,  5,  0,  0, 1'b1, 1'b0); set_exp(9, 3'b111, 2, 3'b011, 3'b100, 3'b000);

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_iss_v", 32'(iss_v_o), 32'd0);
        checkOutput("rst_iss_last", 32'(iss_last_o), 32'd0);
        checkOutput("rst_split", 32'(split_cnt_o), 32'd0);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_bnd_rdy", 32'(bnd_rdy_o), 32'd1);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            drain();
            checkCounts($sformatf("vec%0d", i));
        end

        // Empty bundle is accepted but nothing becomes pending.
        driveBundle(vecs[0]);
        slot_v_i = 3'b000;
        bnd_v_i  = 1'b1;
        tick();
        bnd_v_i = 1'b0;
        @(negedge clk_i);
        checkOutput("empty_iss_v", 32'(iss_v_o), 32'd0);
        checkOutput("empty_bnd_rdy", 32'(bnd_rdy_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Execute stalls for three cycles on the first group.
        iss_rdy_i = 1'b0;
        applyStimulus(vecs[1]);
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("stall_iss_v", 32'(iss_v_o), 32'd1);
            checkOutput("stall_last", 32'(iss_last_o), 32'd0);
            checkOutput("stall_bnd_rdy", 32'(bnd_rdy_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        iss_rdy_i = 1'b1;
        drain();
        checkCounts("stall");

        // Branch bundle flushed while its second group is presented.
        applyStimulus(vecs[2]);
        tick();
        flush_i = 1'b1;
        driveBundle(vecs[0]);
        bnd_v_i = 1'b1;
        @(negedge clk_i);
        scoreboard();
        checkOutput("flush_bnd_rdy", 32'(bnd_rdy_o), 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        bnd_v_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("flush_idle_iss_v", 32'(iss_v_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        checkOutput("flush_sb_empty", 32'(exp_q.size()), 32'd0);
        checkCounts("flush");

        // Next bundle captured in the same cycle the last group issues.
        pushExpect(vecs[0]);
        driveBundle(vecs[0]);
        bnd_v_i = 1'b1;
        tick();
        pushExpect(vecs[1]);
        driveBundle(vecs[1]);
        @(negedge clk_i);
        checkOutput("b2b_bnd_rdy", 32'(bnd_rdy_o), 32'd1);
        scoreboard();
        @(posedge clk_i);
        #1;
        bnd_v_i = 1'b0;
        @(negedge clk_i);
        checkOutput("b2b_no_bubble", 32'(iss_v_o), 32'd1);
        scoreboard();
        @(posedge clk_i);
        #1;
        drain();
        checkCounts("b2b");

        // Two more split bundles with the small counter already pinned at all-ones.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(vecs[4]);
            drain();
            checkCounts("sat");
        end
        checkOutput("sat_all_ones", 32'(sat_cnt), 32'd3);

        // Reset while a bundle is held: discarded, counters cleared at once.
        iss_rdy_i = 1'b0;
        applyStimulus(vecs[1]);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_iss_v", 32'(iss_v_o), 32'd0);
        checkOutput("midrst_split", 32'(split_cnt_o), 32'd0);
        checkOutput("midrst_sat", 32'(sat_cnt), 32'd0);
        exp_q.delete();
        exp_split = 16'd0;
        exp_sat   = 2'd0;
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        iss_rdy_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("postrst_iss_v", 32'(iss_v_o), 32'd0);
            scoreboard();
            @(posedge clk_i);
            #1;
        end
        checkCounts("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfbw_issue_sched.md
RFBW_ISSUE_SCHED -- requirements
Module: rfbw_issue_sched

Interface
REQ-001 SHALL have parameter: REGW, 6, register-number width (64 GPRs, r0 reads as zero).
REQ-002 SHALL have parameter: CNTW, 16, split-event counter width.
REQ-003 SHALL have port: clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: bnd_v_i  in  1  fetch offers a 3-slot bundle.
REQ-006 SHALL have port: bnd_rdy_o  out  1  scheduler accepts the bundle this cycle.
REQ-007 SHALL have port: slot_v_i  in  3  per-slot valid; bit0 is the oldest slot.
REQ-008 SHALL have port: ra_i, rb_i, rc_i  in  3xREGW each  per-slot source register numbers.
REQ-009 SHALL have port: rt_i  in  3xREGW  per-slot destination register number.
REQ-010 SHALL have port: rfwr_i  in  3  per-slot register-file write enable.
REQ-011 SHALL have port: br_i  in  3  per-slot branch flag.
REQ-012 SHALL have port: iss_v_o  out  3  slot mask issued to execute this cycle.
REQ-013 SHALL have port: iss_rdy_i  in  1  execute accepts the presented group.
REQ-014 SHALL have port: iss_last_o  out  1  presented group empties the held bundle.
REQ-015 SHALL have port: flush_i  in  1  taken-branch flush from execute.
REQ-016 SHALL have port: split_cnt_o  out  CNTW  count of bundles needing more than one group.

Function
REQ-017 SHALL use two states: IDLE (no bundle held) and ISSUE (bundle held, pending mask nonzero).
REQ-018 SHALL drive bnd_rdy_o=1 in IDLE, and in ISSUE only when iss_v_o!=0 & iss_rdy_i & iss_last_o & !flush_i.
REQ-019 SHALL capture slot fields into holding registers and set pending=slot_v_i on bnd_v_i & bnd_rdy_o; a capture with slot_v_i=0 stays in IDLE.
REQ-020 SHALL present the first group in the cycle after capture (1-cycle latency); iss_v_o=0 in IDLE.
REQ-021 SHALL form the group from the lowest pending slot upward. The group SHALL add each next pending slot j only while all three conditions hold:
  - no RAW: j's Ra/Rb/Rc does not equal the Rt of any included slot with rfwr=1 and Rt!=0;
  - no WAW: both slots write the same nonzero Rt;
  - no included slot has br=1.
  Grouping SHALL stop at the first excluded slot.
REQ-022 SHALL hold iss_v_o stable while iss_rdy_i=0 and clear the issued bits from pending on iss_v_o!=0 & iss_rdy_i.
REQ-023 SHALL assert iss_last_o when the presented group equals pending.
REQ-024 SHALL return to IDLE when pending becomes zero; with bnd_v_i high in the same cycle, it SHALL capture the next bundle (back-to-back, no bubble).
REQ-025 SHALL increment split_cnt_o once per bundle, on acceptance of its first group when iss_last_o=0, and SHALL saturate at all-ones.
REQ-026 SHALL, on flush_i, clear pending and enter IDLE next cycle, suppress any same-cycle capture (bnd_rdy_o=0), and leave split_cnt_o unchanged except for a same-cycle accepted first group.
REQ-027 SHALL treat dependencies on r0 as nonexistent.

Reset
REQ-028 SHALL, on rst_i, immediately set: state IDLE, pending 0, holding registers 0, iss_v_o 0, iss_last_o 0, bnd_rdy_o 1 (once released), split_cnt_o 0.
REQ-029 SHALL discard a bundle held when reset asserts mid-operation, with no group issued after release.

Structure
REQ-030 SHALL place the REGW-based register-number typedef and the IDLE/ISSUE state enum in rfBlackWidowPkg.
REQ-031 SHALL implement pairwise hazard detection as one combinational sub-module rfbw_dep_chk (older slot fields, younger slot fields -> hazard bit), instantiated three times (0-1, 0-2, 1-2).

Verification
REQ-032 SHALL cover independent bundle (r1<-r2, r3<-r4, r5<-r6), iss_rdy_i=1 -> single group iss_v_o=111, iss_last_o=1, split_cnt_o stays 0.
REQ-033 SHALL cover RAW slot1 reads r7 written by slot0 -> groups 001 then 110; split_cnt_o=1.
REQ-034 SHALL cover slot0 br=1 with slot1 and slot2 valid -> groups 001 then 110; flush_i in the second group's cycle -> IDLE, no further iss_v_o.
REQ-035 SHALL cover slot0 writes r0 and slot1 reads r0 -> single group 111.
REQ-036 SHALL cover iss_rdy_i low 3 cycles during group 001 -> iss_v_o held at 001, pending unchanged, bnd_rdy_o=0.
REQ-037 SHALL cover split_cnt_o preset near 16'hFFFF via 2 split bundles -> value stays 16'hFFFF; rst_i mid-ISSUE -> iss_v_o=0 immediately, split_cnt_o=0.
